ps2_transmitter: RTL and testbench

PS2_TRANSMITTER -- requirements
Module: ps2_transmitter

---
 rtl/ps2_transmitter.sv | 174 +++++++++++++++++
 tb/tb_ps2_transmitter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11-bit frame clocked by the device, ack check.
// Optional watchdog on device clock edges is enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       PS2Clk_in,
    input  logic       PS2Data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQUEST,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    state_t           state_reg, state_next;
    logic [2:0]       clk_sync_reg;
    logic [1:0]       data_sync_reg;
    logic [8:0]       shift_reg, shift_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
    logic             nack_reg, nack_next;
    logic             data_oe_reg, data_oe_next;

    logic clk_s, data_s, fall;

    // [1] is the synchronized level, [2] its previous value for edge detection
    assign clk_s  = clk_sync_reg[1];
    assign data_s = data_sync_reg[1];
    assign fall   = clk_sync_reg[2] & ~clk_sync_reg[1];

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog_reg, wdog_next;
    logic            watched, timeout_hit;

    assign watched     = (state_reg == ST_SEND) || (state_reg == ST_ACK) || (state_reg == ST_WAIT_IDLE);
    assign timeout_hit = watched && (wdog_reg == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            clk_sync_reg  <= 3'b111;
            data_sync_reg <= 2'b11;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            inh_cnt_reg   <= '0;
            nack_reg      <= 1'b0;
            data_oe_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clk_sync_reg  <= {clk_sync_reg[1:0], PS2Clk_in};
            data_sync_reg <= {data_sync_reg[0], PS2Data_in};
            shift_reg     <= shift_next;
            bit_cnt_reg   <= bit_cnt_next;
            inh_cnt_reg   <= inh_cnt_next;
            nack_reg      <= nack_next;
            data_oe_reg   <= data_oe_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        inh_cnt_next = inh_cnt_reg;
        nack_next    = nack_reg;
        data_oe_next = data_oe_reg;
        tx_ready     = 1'b0;
        ps2clk_oe    = 1'b0;
        ps2data_oe   = 1'b0;
        tx_done      = 1'b0;
        tx_err       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                tx_ready     = 1'b1;
                data_oe_next = 1'b0;
                if (tx_valid) begin
                    // odd parity: bit is 1 when the byte holds an even count of ones
                    shift_next   = {~^tx_data, tx_data};
                    bit_cnt_next = '0;
                    inh_cnt_next = '0;
                    nack_next    = 1'b0;
                    state_next   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                ps2clk_oe = 1'b1;
                if (inh_cnt_reg == INH_W'(INHIBIT_CYCLES - 1)) begin
                    state_next = ST_REQUEST;
                end else begin
                    inh_cnt_next = inh_cnt_reg + INH_W'(1);
                end
            end
            ST_REQUEST: begin
                ps2clk_oe    = 1'b1;
                ps2data_oe   = 1'b1;
                data_oe_next = 1'b1;  // start bit stays driven until the first device edge
                state_next   = ST_SEND;
            end
            ST_SEND: begin
                ps2data_oe = data_oe_reg;
                if (fall) begin
                    // ones shift in behind the parity bit, so the 10th edge presents the stop bit
                    data_oe_next = ~shift_reg[0];
                    shift_next   = {1'b1, shift_reg[8:1]};
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd9) begin
                        state_next = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (fall) begin
                    nack_next  = data_s;
                    state_next = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    tx_done    = 1'b1;
                    tx_err     = nack_reg;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        if (timeout_hit) begin
            ps2data_oe   = 1'b0;
            data_oe_next = 1'b0;
            tx_done      = 1'b1;
            tx_err       = 1'b1;
            state_next   = ST_IDLE;
        end
`endif
    end

`ifdef PS2_TX_TIMEOUT_EN
    always_comb begin
        wdog_next = '0;
        if (watched && !fall && (state_next == state_reg)) begin
            wdog_next = wdog_reg + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_reg <= '0;
        end else begin
            wdog_reg <= wdog_next;
        end
    end
`endif

endmodule

// File: tb/tb_ps2_transmitter.sv
// Self-checking bench for ps2_transmitter: behavioural PS/2 device on a wired-AND bus and a frame reference model.
module tb_ps2_transmitter;

    localparam int INH = 40;
    localparam int TMO = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       tx_ready, ps2clk_oe, ps2data_oe, tx_done, tx_err;
    logic       PS2Clk_in, PS2Data_in;

    int   checks = 0;
    int   failures = 0;
    int   done_count = 0;
    logic last_err = 1'b0;

    // open-drain bus with pull-ups: a line is high only when nobody pulls it
    assign PS2Clk_in  = dev_clk & ~ps2clk_oe;
    assign PS2Data_in = dev_data & ~ps2data_oe;

    ps2_transmitter #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .PS2Clk_in (PS2Clk_in),
        .PS2Data_in(PS2Data_in),
        .ps2clk_oe (ps2clk_oe),
        .ps2data_oe(ps2data_oe),
        .tx_done   (tx_done),
        .tx_err    (tx_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // released line levels on device edges 1..10: data LSB first, odd parity, stop
    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        logic [9:0] f;
        f[7:0] = b;
        f[8]   = (($countones(b) % 2) == 0);
        f[9]   = 1'b1;
        return f;
    endfunction

    // completion monitor: counts tx_done pulses and checks the pulse/err rules every cycle
    initial begin
        logic done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_done) begin
                done_count++;
                last_err = tx_err;
            end else begin
                chk("err_without_done", {31'd0, tx_err}, 32'd0);
            end
            if (done_prev) begin
                chk("done_one_cycle", {31'd0, tx_done}, 32'd0);
                chk("ready_after_done", {31'd0, tx_ready}, 32'd1);
            end
            done_prev = tx_done;
        end
    end

    task automatic begin_xfer(input logic [7:0] b);
        int n;
        n = 0;
        while (!tx_ready && n < 100) begin
            tick();
            n++;
        end
        chk("ready_before", {31'd0, tx_ready}, 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        n = 0;
        while (ps2clk_oe && !ps2data_oe && n < INH + 10) begin
            n++;
            tick();
        end
        chk("inhibit_len", n, INH);
        chk("req_clk_oe", {31'd0, ps2clk_oe}, 32'd1);
        chk("req_start_oe", {31'd0, ps2data_oe}, 32'd1);
        tick();
        chk("req_one_cycle", {31'd0, ps2clk_oe}, 32'd0);
        ticks(4);
        chk("start_bit_line", {31'd0, PS2Data_in}, 32'd0);
    endtask

    task automatic clock_bits(input logic [9:0] exp, input int nbits, input bit inject);
        int h;
        for (int k = 0; k < nbits; k++) begin
            h = $urandom_range(4, 9);
            dev_clk = 1'b0;
            ticks(h);
            chk($sformatf("bit%0d", k + 1), {31'd0, PS2Data_in}, {31'd0, exp[k]});
            dev_clk = 1'b1;
            ticks(h);
            if (inject && k == 2) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                tick();
                tx_valid = 1'b0;
                chk("busy_not_ready", {31'd0, tx_ready}, 32'd0);
            end
        end
    endtask

    task automatic xfer(input logic [7:0] b, input bit ack, input bit inject);
        int n, h, dc0;
        logic [9:0] exp;
        exp = frame_bits(b);
        dc0 = done_count;
        begin_xfer(b);
        clock_bits(exp, 10, inject);
        chk("ack_phase_release", {31'd0, ps2data_oe}, 32'd0);
        h = $urandom_range(4, 9);
        dev_data = ack ? 1'b0 : 1'b1;
        ticks(h);
        dev_clk = 1'b0;
        ticks(h);
        dev_clk = 1'b1;
        ticks(h);
        dev_data = 1'b1;
        n = 0;
        while (done_count == dc0 && n < 50) begin
            tick();
            n++;
        end
        chk("done_count", done_count - dc0, 1);
        chk("tx_err", {31'd0, last_err}, {31'd0, ~ack});
        tick();
        chk("ready_after", {31'd0, tx_ready}, 32'd1);
        chk("clk_released", {31'd0, ps2clk_oe}, 32'd0);
        $display("xfer byte=%02h ack=%0d parity=%0d err=%0d", b, ack, exp[8], last_err);
    endtask

    initial begin
        int   n, dc0;
        logic [7:0] rb;
        bit   rack;

        ticks(3);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_clk_oe", {31'd0, ps2clk_oe}, 32'd0);
        chk("rst_data_oe", {31'd0, ps2data_oe}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        chk("rst_err", {31'd0, tx_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        xfer(8'hED, 1'b1, 1'b0);
        xfer(8'h01, 1'b1, 1'b0);
        xfer(8'hFF, 1'b1, 1'b0);
        xfer(8'hF4, 1'b0, 1'b0);
        xfer(8'hAA, 1'b1, 1'b1);
        ticks(20);
        chk("no_ghost_start", {31'd0, ps2clk_oe}, 32'd0);
        chk("idle_ready", {31'd0, tx_ready}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            rb   = 8'($urandom);
            rack = 1'($urandom_range(0, 1));
            xfer(rb, rack, 1'b0);
        end

        // reset mid-frame
        dc0 = done_count;
        begin_xfer(8'hF0);
        clock_bits(frame_bits(8'hF0), 4, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("midrst_clk_oe", {31'd0, ps2clk_oe}, 32'd0);
        chk("midrst_data_oe", {31'd0, ps2data_oe}, 32'd0);
        chk("midrst_ready", {31'd0, tx_ready}, 32'd1);
        rst_n = 1'b1;
        ticks(20);
        chk("midrst_no_done", done_count - dc0, 0);
        chk("midrst_idle", {31'd0, tx_ready}, 32'd1);
        $display("xfer byte=f0 aborted by reset after edge 4");

        // device stops clocking after edge 3
        dc0 = done_count;
        begin_xfer(8'h3C);
        clock_bits(frame_bits(8'h3C), 2, 1'b0);
        dev_clk = 1'b0;
        n = 0;
`ifdef PS2_TX_TIMEOUT_EN
        while (!tx_done && n < TMO + 50) begin
            tick();
            n++;
            if (n == 6) dev_clk = 1'b1;
        end
        // two synchronizer stages then TIMEOUT_CYCLES counted from the detected edge
        chk("timeout_latency", n, TMO + 2);
        chk("timeout_err", {31'd0, tx_err}, 32'd1);
        chk("timeout_clk_oe", {31'd0, ps2clk_oe}, 32'd0);
        chk("timeout_data_oe", {31'd0, ps2data_oe}, 32'd0);
        tick();
        chk("timeout_ready", {31'd0, tx_ready}, 32'd1);
        $display("xfer byte=3c timed out after %0d cycles", n);
`else
        while (!tx_done && n < 3 * TMO) begin
            tick();
            n++;
            if (n == 6) dev_clk = 1'b1;
        end
        chk("stall_no_done", done_count - dc0, 0);
        chk("stall_busy", {31'd0, tx_ready}, 32'd0);
        chk("stall_clk_released", {31'd0, ps2clk_oe}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("stall_recover", {31'd0, tx_ready}, 32'd1);
        $display("xfer byte=3c stalled in send for %0d cycles", n);
`endif

        ticks(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
